// File: rtl/fde_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, one-hot opcode
// positions and the stage-control bundle decoded from the current state.
package fde_pkg;

    localparam int OPCODE_W = 16;
    localparam int REG_W    = 5;
    localparam int LEN_W    = 4;
    localparam int PERF_W   = 16;

    // One-hot opcode bit positions in the decode stage
    localparam int OP_HLT = 13;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic wb_en;
        logic id_flush;
        logic ex_bubble;
        logic halted;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [1:0] st);
        ctrl_t c;
        c = '{if_en: 1'b1, id_en: 1'b1, ex_en: 1'b1, wb_en: 1'b1,
              id_flush: 1'b0, ex_bubble: 1'b0, halted: 1'b0};
        case (st)
            ST_STALL: begin
                c.if_en     = 1'b0;
                c.id_en     = 1'b0;
                c.ex_bubble = 1'b1;
            end
            ST_FLUSH: c.id_flush = 1'b1;
            ST_HALT: begin
                c.if_en  = 1'b0;
                c.id_en  = 1'b0;
                c.ex_en  = 1'b0;
                c.wb_en  = 1'b0;
                c.halted = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Read-after-write hazard check between the instruction in decode and the
// result pending in execute. Purely combinational.
module hazard_detect
    import fde_pkg::*;
(
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    ex_dest,
    input  logic                ex_wr_en,
    output logic                hazard
);

    // Register 0 is hardwired zero, so a write to it never creates a dependency
    assign hazard = ex_wr_en
                 && (ex_dest != '0)
                 && (id_opcode != '0)
                 && ((ex_dest == id_rs) || (ex_dest == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Moore FSM sequencing the fetch/decode/execute/writeback pipeline through
// RUN, STALL, FLUSH and HALT. Define PIPE_PERF_CNT_EN to build the stall and
// flush event counters; otherwise stall_cnt and flush_cnt read as zero.
module pipeline_ctrl
    import fde_pkg::*;
#(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    ex_dest,
    input  logic                ex_wr_en,
    input  logic                ex_br_taken,
    input  logic                resume,
    output logic                if_en,
    output logic                id_en,
    output logic                ex_en,
    output logic                wb_en,
    output logic                id_flush,
    output logic                ex_bubble,
    output logic                halted,
    output logic [1:0]          state,
    output logic [PERF_W-1:0]   stall_cnt,
    output logic [PERF_W-1:0]   flush_cnt
);

    localparam logic [LEN_W-1:0] STALL_LEN = LEN_W'(STALL_CYCLES - 1);
    localparam logic [LEN_W-1:0] FLUSH_LEN = LEN_W'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic             hazard;
    ctrl_t            ctrl;

    hazard_detect u_hazard (
        .id_opcode (id_opcode),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .ex_dest   (ex_dest),
        .ex_wr_en  (ex_wr_en),
        .hazard    (hazard)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns both signals; a missing
        // branch would otherwise infer a latch.
        state_nxt = state_q;
        len_nxt   = len_q;
        case (state_q)
            ST_RUN: begin
                if (ex_br_taken) begin
                    state_nxt = ST_FLUSH;
                    len_nxt   = FLUSH_LEN;
                end else if (hazard) begin
                    state_nxt = ST_STALL;
                    len_nxt   = STALL_LEN;
                end else if (id_opcode[OP_HLT]) begin
                    state_nxt = ST_HALT;
                    len_nxt   = '0;
                end
            end
            ST_STALL, ST_FLUSH: begin
                // A taken branch squashes whatever is being held or flushed
                if (ex_br_taken) begin
                    state_nxt = ST_FLUSH;
                    len_nxt   = FLUSH_LEN;
                end else if (len_q == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    len_nxt = len_q - 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            len_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values,
            // independent of statement order.
            state_q <= state_nxt;
            len_q   <= len_nxt;
        end
    end

    assign ctrl      = decode_ctrl(state_q);
    assign if_en     = ctrl.if_en;
    assign id_en     = ctrl.id_en;
    assign ex_en     = ctrl.ex_en;
    assign wb_en     = ctrl.wb_en;
    assign id_flush  = ctrl.id_flush;
    assign ex_bubble = ctrl.ex_bubble;
    assign halted    = ctrl.halted;
    assign state     = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic              stall_entry, flush_entry;
    logic [PERF_W-1:0] stall_q, flush_q;

    // Every taken branch outside HALT is a (re)entry into FLUSH
    assign stall_entry = (state_q == ST_RUN) && (state_nxt == ST_STALL);
    assign flush_entry = ex_br_taken && (state_q != ST_HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_entry && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_entry && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 2, number of bubble cycles inserted per RAW hazard (1..15).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles the ID stage is flushed after a taken branch (1..15).
REQ-003 SHALL have port clock  in  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port id_opcode  in  16  one-hot opcode of the instruction in decode; all-zero means empty slot.
REQ-006 SHALL have ports id_rs and id_rt  in  5 each  source and target register addresses in decode.
REQ-007 SHALL have port ex_dest  in  5  destination register address of the instruction in execute.
REQ-008 SHALL have port ex_wr_en  in  1  execute result will be written back.
REQ-009 SHALL have port ex_br_taken  in  1  execute resolved a taken branch this cycle.
REQ-010 SHALL have port resume  in  1  single-cycle pulse releasing HALT.
REQ-011 SHALL have ports if_en, id_en, ex_en, wb_en  out  1 each  stage advance enables.
REQ-012 SHALL have port id_flush  out  1  replace decode contents with NOP.
REQ-013 SHALL have port ex_bubble  out  1  force NOP opcode into execute.
REQ-014 SHALL have port halted  out  1  pipeline halted.
REQ-015 SHALL have port state  out  2  current state encoding.
REQ-016 SHALL have ports stall_cnt and flush_cnt  out  16 each  event counters.

Function
REQ-017 SHALL implement a Moore FSM with states RUN=0, STALL=1, FLUSH=2, HALT=3; all outputs decode from registered state/counter only.
REQ-018 SHALL drive, in RUN: all four enables 1, id_flush 0, ex_bubble 0, halted 0.
REQ-019 SHALL detect a hazard when ex_wr_en=1, ex_dest!=0, id_opcode!=0, and ex_dest equals id_rs or id_rt.
REQ-020 SHALL, from RUN, transition with priority: ex_br_taken -> FLUSH; else hazard -> STALL; else id_opcode==HLT (bit 13) -> HALT; else stay RUN.
REQ-021 SHALL, in STALL: if_en=0, id_en=0, ex_en=1, wb_en=1, ex_bubble=1; remain exactly STALL_CYCLES cycles, then RUN.
REQ-022 SHALL, in FLUSH: if_en=1, id_en=1, ex_en=1, wb_en=1, id_flush=1; remain exactly FLUSH_CYCLES cycles, then RUN.
REQ-023 SHALL, in HALT: all enables 0, halted=1; leave to RUN on the cycle after resume=1; ignore all other inputs.
REQ-024 SHALL let ex_br_taken arriving in STALL abort the stall and enter FLUSH with a fresh FLUSH_CYCLES count.
REQ-025 SHALL ignore hazard and HLT while in FLUSH; ex_br_taken in FLUSH restarts the FLUSH count.
REQ-026 SHALL load a 4-bit down-counter with length-1 on state entry and exit when it reaches 0.
REQ-027 SHALL have one-cycle decision latency: input sampled at edge N drives outputs after edge N.

Reset
REQ-028 SHALL on reset_n low immediately force state RUN, counters 0, if_en=id_en=ex_en=wb_en=1, id_flush=0, ex_bubble=0, halted=0.
REQ-029 SHALL abandon any STALL/FLUSH/HALT in progress when reset asserts mid-operation; release is synchronous to the next clock edge.

Configuration
REQ-030 SHALL, with PIPE_PERF_CNT_EN defined, increment stall_cnt on each RUN->STALL entry and flush_cnt on each entry into FLUSH (including restarts), both saturating at 16'hFFFF.
REQ-031 SHALL, without PIPE_PERF_CNT_EN, tie stall_cnt and flush_cnt to 0 and implement no counter flops.

Structure
REQ-032 SHALL take the one-hot opcode constants (HLT bit 13 etc.) and state encodings from shared package fde_pkg.
REQ-033 SHALL place the hazard comparison in combinational sub-module hazard_detect.

Verification
REQ-034 SHALL cover: ex_wr_en=1, ex_dest=5, id_rs=5, STALL_CYCLES=2 -> if_en=0, ex_bubble=1 for exactly 2 cycles, then RUN; stall_cnt=1.
REQ-035 SHALL cover: ex_br_taken pulse in RUN -> id_flush=1 for 2 cycles; flush_cnt=1.
REQ-036 SHALL cover: id_opcode=16'h2000 -> halted=1, enables 0 indefinitely; resume pulse -> RUN next cycle.
REQ-037 SHALL cover: hazard and ex_br_taken same cycle -> FLUSH, stall_cnt unchanged; ex_dest=0 matching id_rs=0 -> no stall.
REQ-038 SHALL cover: reset_n low during STALL second cycle -> outputs at reset values without a clock edge.
